// File: rtl/esl_clk_flag_mon_pkg.sv
// Shared types and constants for the clock-checker flag monitor.
// Fault codes describe the latched cause. State encoding 3 is never entered on purpose.
package esl_clk_flag_mon_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_LOW     = 3'd1;
    localparam logic [2:0] FC_HIGH    = 3'd2;
    localparam logic [2:0] FC_DIFF    = 3'd3;
    localparam logic [2:0] FC_INT     = 3'd4;
    localparam logic [2:0] FC_TMO     = 3'd5;
    localparam logic [2:0] FC_ILLEGAL = 3'd7;

    localparam logic [15:0] PASS_MAX = 16'hFFFF;

    // A flag pair is healthy only when it is complementary and reports no error.
    function automatic logic pair_ok(input logic err, input logic err_n);
        return ~err & err_n;
    endfunction

    function automatic logic pair_fail(input logic err, input logic err_n);
        return err & ~err_n;
    endfunction

endpackage

// File: rtl/esl_clk_flag_mon_tmo.sv
// Saturating watchdog that counts cycles since the last check_done edge.
// The expired flag stays high once the limit is reached until the counter is cleared.
module esl_clk_flag_mon_tmo #(
    parameter int unsigned DONE_TIMEOUT = 44000000
) (
    input  logic ref_clk,
    input  logic ref_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DONE_TIMEOUT);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && (cnt_reg != LIMIT)) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign expired = (cnt_reg == LIMIT);

endmodule

// File: rtl/esl_clk_flag_mon.sv
// Supervises a clock checker's error flags and demands a safe state on any fault.
// All inputs pass through one register stage; every decision uses the registered copies.
module esl_clk_flag_mon
    import esl_clk_flag_mon_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 44000000,
    parameter int unsigned MISMATCH_THR = 3,
    parameter int unsigned EVAL_DLY     = 2
) (
    input  logic        ref_clk,
    input  logic        ref_rst_n,
    input  logic        error,
    input  logic        error_n,
    input  logic        freq_too_high,
    input  logic        check_done,
    input  logic        int_error,
    input  logic        clear_req,
    output logic        safe_state_req,
    output logic        safe_state_req_n,
    output logic [2:0]  fault_code,
    output logic [1:0]  mon_state,
    output logic [15:0] pass_count
);

    localparam int unsigned DLY_W = (EVAL_DLY < 1) ? 1 : $clog2(EVAL_DLY + 1);
    localparam int unsigned MIS_W = $clog2(MISMATCH_THR + 1);
    localparam logic [MIS_W-1:0] MIS_MAX  = MIS_W'(MISMATCH_THR);
    localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(MISMATCH_THR - 1);

    logic error_reg, error_n_reg, freq_reg, done_reg, done_prev_reg, int_reg, clear_reg;
    logic [DLY_W-1:0] dly_reg;
    logic [MIS_W-1:0] mis_reg;
    logic [1:0]       state_reg, state_next;
    logic [2:0]       fault_reg, fault_next;
    logic [15:0]      pass_reg, pass_next;
    logic             safe_reg, safe_next;

    logic done_rise, verdict, verdict_pass, verdict_fail;
    logic mismatch, diff_fault, tmo_expired, tmo_clear, active;

    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            error_reg     <= 1'b0;
            error_n_reg   <= 1'b0;
            freq_reg      <= 1'b0;
            done_reg      <= 1'b0;
            done_prev_reg <= 1'b0;
            int_reg       <= 1'b0;
            clear_reg     <= 1'b0;
        end else begin
            error_reg     <= error;
            error_n_reg   <= error_n;
            freq_reg      <= freq_too_high;
            done_reg      <= check_done;
            done_prev_reg <= done_reg;
            int_reg       <= int_error;
            clear_reg     <= clear_req;
        end
    end

    assign done_rise = done_reg & ~done_prev_reg;

    // A new edge reloads the delay, so back-to-back edges yield a single verdict.
    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            dly_reg <= '0;
        end else if (done_rise) begin
            dly_reg <= DLY_W'(EVAL_DLY);
        end else if (dly_reg != '0) begin
            dly_reg <= dly_reg - DLY_W'(1);
        end
    end

    assign verdict      = (EVAL_DLY == 0) ? done_rise : ((dly_reg == DLY_W'(1)) && !done_rise);
    assign verdict_pass = verdict & pair_ok(error_reg, error_n_reg);
    assign verdict_fail = verdict & pair_fail(error_reg, error_n_reg);

    assign active   = (state_reg == ST_INIT) || (state_reg == ST_MONITOR);
    assign mismatch = (error_reg == error_n_reg);

    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            mis_reg <= '0;
        end else if (!active || !mismatch) begin
            mis_reg <= '0;
        end else if (mis_reg != MIS_MAX) begin
            mis_reg <= mis_reg + MIS_W'(1);
        end
    end

    assign diff_fault = mismatch && (mis_reg >= MIS_LAST);

    // Holding the watchdog clear through FAULT makes it start from zero on entry to INIT.
    assign tmo_clear = done_rise || (state_reg == ST_FAULT);

    esl_clk_flag_mon_tmo #(
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) u_tmo (
        .ref_clk   (ref_clk),
        .ref_rst_n (ref_rst_n),
        .clear     (tmo_clear),
        .enable    (active),
        .expired   (tmo_expired)
    );

    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        pass_next  = pass_reg;
        case (state_reg)
            ST_INIT, ST_MONITOR: begin
                if (int_reg) begin
                    state_next = ST_FAULT;
                    fault_next = FC_INT;
                end else if (diff_fault) begin
                    state_next = ST_FAULT;
                    fault_next = FC_DIFF;
                end else if (verdict_fail) begin
                    state_next = ST_FAULT;
                    fault_next = freq_reg ? FC_HIGH : FC_LOW;
                end else if (tmo_expired) begin
                    state_next = ST_FAULT;
                    fault_next = FC_TMO;
                end else if (verdict_pass) begin
                    state_next = ST_MONITOR;
                    if (pass_reg != PASS_MAX) begin
                        pass_next = pass_reg + 16'd1;
                    end
                end
            end
            ST_FAULT: begin
                if (clear_reg && pair_ok(error_reg, error_n_reg) && !int_reg) begin
                    state_next = ST_INIT;
                    fault_next = FC_NONE;
                    pass_next  = '0;
                end
            end
            default: begin
                state_next = ST_FAULT;
                fault_next = FC_ILLEGAL;
            end
        endcase
        safe_next = (state_next != ST_MONITOR);
    end

    always_ff @(posedge ref_clk or negedge ref_rst_n) begin
        if (!ref_rst_n) begin
            state_reg <= ST_INIT;
            fault_reg <= FC_NONE;
            pass_reg  <= '0;
            safe_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            fault_reg <= fault_next;
            pass_reg  <= pass_next;
            safe_reg  <= safe_next;
        end
    end

    assign mon_state        = state_reg;
    assign fault_code       = fault_reg;
    assign pass_count       = pass_reg;
    assign safe_state_req   = safe_reg;
    assign safe_state_req_n = ~safe_reg;

endmodule

// File: tb/tb_esl_clk_flag_mon.sv
// Directed bench for esl_clk_flag_mon with a short timeout window.
// Expected values are written by hand from the intended cycle behaviour.
module tb_esl_clk_flag_mon;

    logic        ref_clk;
    logic        ref_rst_n;
    logic        error;
    logic        error_n;
    logic        freq_too_high;
    logic        check_done;
    logic        int_error;
    logic        clear_req;
    logic        safe_state_req;
    logic        safe_state_req_n;
    logic [2:0]  fault_code;
    logic [1:0]  mon_state;
    logic [15:0] pass_count;

    int n_checks = 0;
    int n_pass   = 0;

    esl_clk_flag_mon #(
        .DONE_TIMEOUT (100),
        .MISMATCH_THR (3),
        .EVAL_DLY     (2)
    ) dut (
        .ref_clk          (ref_clk),
        .ref_rst_n        (ref_rst_n),
        .error            (error),
        .error_n          (error_n),
        .freq_too_high    (freq_too_high),
        .check_done       (check_done),
        .int_error        (int_error),
        .clear_req        (clear_req),
        .safe_state_req   (safe_state_req),
        .safe_state_req_n (safe_state_req_n),
        .fault_code       (fault_code),
        .mon_state        (mon_state),
        .pass_count       (pass_count)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-16s got %0h expected %0h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-16s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle check_done pulse; returns after the verdict has reached the state register.
    task automatic do_pulse();
        check_done = 1'b1;
        tick();
        check_done = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_clear();
        error         = 1'b0;
        error_n       = 1'b1;
        int_error     = 1'b0;
        freq_too_high = 1'b0;
        repeat (2) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        ref_rst_n     = 1'b0;
        error         = 1'b0;
        error_n       = 1'b1;
        freq_too_high = 1'b0;
        check_done    = 1'b0;
        int_error     = 1'b0;
        clear_req     = 1'b0;
        repeat (3) tick();
        check("rst_state", 16'(mon_state), 16'd0);
        check("rst_safe", 16'(safe_state_req), 16'd1);
        check("rst_safe_n", 16'(safe_state_req_n), 16'd0);
        check("rst_fault", 16'(fault_code), 16'd0);
        check("rst_pass", pass_count, 16'd0);
        ref_rst_n = 1'b1;
        tick();

        // Five healthy checks, 50 cycles apart
        for (int i = 0; i < 5; i++) begin
            do_pulse();
            if (i == 0) begin
                check("mon_state", 16'(mon_state), 16'd1);
                check("mon_safe", 16'(safe_state_req), 16'd0);
                check("mon_safe_n", 16'(safe_state_req_n), 16'd1);
            end
            repeat (45) tick();
        end
        check("pass_5", pass_count, 16'd5);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        check("clr_ign_state", 16'(mon_state), 16'd1);
        check("clr_ign_pass", pass_count, 16'd5);

        // Second edge while a verdict is pending restarts the delay: one increment only
        check_done = 1'b1; tick();
        check_done = 1'b0; tick();
        check_done = 1'b1; tick();
        check_done = 1'b0;
        repeat (6) tick();
        check("restart_pass", pass_count, 16'd6);

        error = 1'b1; error_n = 1'b0; freq_too_high = 1'b1;
        do_pulse();
        check("high_state", 16'(mon_state), 16'd2);
        check("high_code", 16'(fault_code), 16'd2);
        check("high_safe", 16'(safe_state_req), 16'd1);
        check("high_pass", pass_count, 16'd6);

        int_error = 1'b1; tick();
        int_error = 1'b0; tick();
        check("fault_hold", 16'(fault_code), 16'd2);

        clear_req = 1'b1; tick();
        clear_req = 1'b0;
        repeat (2) tick();
        check("clr_bad_state", 16'(mon_state), 16'd2);

        do_clear();
        check("clr_state", 16'(mon_state), 16'd0);
        check("clr_code", 16'(fault_code), 16'd0);
        check("clr_pass", pass_count, 16'd0);
        check("clr_safe", 16'(safe_state_req), 16'd1);

        do_pulse();
        check("init_pass_st", 16'(mon_state), 16'd1);
        check("init_pass_cnt", pass_count, 16'd1);
        error = 1'b1; error_n = 1'b0; freq_too_high = 1'b0;
        do_pulse();
        check("low_code", 16'(fault_code), 16'd1);
        do_clear();

        // Mismatch for two cycles is tolerated, three is a fault
        do_pulse();
        error = 1'b1; error_n = 1'b1;
        repeat (2) tick();
        error = 1'b0;
        repeat (3) tick();
        check("diff2_state", 16'(mon_state), 16'd1);
        error = 1'b1;
        repeat (3) tick();
        error = 1'b0;
        repeat (3) tick();
        check("diff3_state", 16'(mon_state), 16'd2);
        check("diff3_code", 16'(fault_code), 16'd3);
        do_clear();

        do_pulse();
        repeat (85) tick();
        check("tmo_early", 16'(mon_state), 16'd1);
        repeat (20) tick();
        check("tmo_state", 16'(mon_state), 16'd2);
        check("tmo_code", 16'(fault_code), 16'd5);
        do_clear();

        // Internal error coinciding with the third mismatch cycle wins
        do_pulse();
        error = 1'b1; error_n = 1'b1;
        repeat (2) tick();
        int_error = 1'b1;
        tick();
        int_error = 1'b0; error = 1'b0;
        repeat (3) tick();
        check("int_state", 16'(mon_state), 16'd2);
        check("int_code", 16'(fault_code), 16'd4);

        // Asynchronous reset from FAULT, sampled before the next clock edge
        ref_rst_n = 1'b0;
        #2;
        check("arst_state", 16'(mon_state), 16'd0);
        check("arst_safe", 16'(safe_state_req), 16'd1);
        check("arst_safe_n", 16'(safe_state_req_n), 16'd0);
        check("arst_code", 16'(fault_code), 16'd0);
        check("arst_pass", pass_count, 16'd0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
